hash_light_stream: RTL and testbench
====================================

// Module: hash_light_stream
// PURPOSE
// - Parametrised iterative lightweight hash engine. Absorbs a stream of N_BYTES-wide message
//   blocks over a valid/ready handshake, chains them into an N_BYTES state, runs N_ROUNDS rounds per
//   block and emits the finalised digest on a held valid/ready output.
// - Successor to the single-block 4-byte hash core. Adds multi-block chaining, width/round
//   parameters, back-pressure on both sides and a per-message IV latch.
// PARAMETERS
// - N_BYTES   4   bytes per message block, state, IV and digest (>=2)
// - N_ROUNDS  24  rounds applied per absorbed block (1..255)
// PORTS
// - clk        in   1          single clock, all state on rising edge
// - rst        in   1          reset: asynchronous, active-high
// - in_valid   in   1          message block offered
// - in_ready   out  1          engine can accept a block this cycle
// - in_first   in   1          block is first of a message (latch IV, seed state)
// - in_last    in   1          block is last of a message (finalise after rounds)
// - in_block   in   8*N_BYTES  message block, byte i = bits [8i+7:8i]
// - iv         in   8*N_BYTES  initial value, sampled only on an accepted in_first block
// - out_valid  out  1          digest valid, held until out_ready
// - out_ready  in   1          consumer accepts digest
// - digest     out  8*N_BYTES  finalised digest, stable while out_valid
// - busy       out  1          high in ROUND/FINAL/OUT
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, H, iv_q, digest, round counter=0; in_ready=1, out_valid=0, busy=0.
// - FSM: IDLE -> ROUND -> (WAIT | FINAL) ; WAIT -> ROUND ; FINAL -> OUT -> IDLE.
// - IDLE: in_ready=1. Accept (in_valid&in_ready) with in_first=1: iv_q<=iv, H<=in_block, rc<=0,
//   last_q<=in_last, go ROUND. Block without in_first in IDLE: dropped (not accepted-in_ready still 1, no state change).
// - WAIT (mid-message): in_ready=1. Accept with in_first=0: H<=H^in_block, go ROUND. Accept with
//   in_first=1: restart message exactly as in IDLE (previous chain discarded).
// - ROUND: in_ready=0; one round per cycle, rc increments 0..N_ROUNDS-1. After round N_ROUNDS-1:
//   last_q ? FINAL : WAIT.
// - Round r (bytes mod 256, indices mod N_BYTES): x[i] = H[i+1] ^ iv_q[i] ^ r[7:0];
//   H'[i] = rotl8(H[i] + x[i], 3). All bytes update simultaneously from old H.
// - FINAL: digest[i] <= H[i] ^ iv_q[N_BYTES-1-i]; go OUT. One cycle.
// - OUT: out_valid=1, digest held; on out_ready go IDLE (out_valid drops next cycle). in_ready=0.
// - Latency: single-block message accepted at edge E -> out_valid high after edge E+N_ROUNDS+1;
//   each extra block adds N_ROUNDS+1 cycles (rounds plus one WAIT-accept cycle minimum).
// - No combinational path in_valid->in_ready or out_ready->out_valid; in_ready decoded from state only.
// - iv input changes outside an accepted first block have no effect.
// - Reset mid-ROUND or mid-OUT: everything returns to reset values on assertion, no digest emitted.
// STRUCTURE
// - Package hash_light_pkg: state enum (IDLE, ROUND, WAIT, FINAL, OUT), ROT_AMT=3, rotl8 function.
// - Sub-module hash_light_round (combinational, parameter N_BYTES): in H, iv_q, r; out H'.
// - Top: FSM, rc counter ($clog2(N_ROUNDS) bits min 1), H/iv_q/digest registers, finaliser.
// TESTING
// - Reset: assert rst mid-ROUND -> next cycle in_ready=1, out_valid=0, busy=0, digest=0.
// - Single block N_BYTES=4,N_ROUNDS=24, m=32'h0403_0201, iv=32'h0 -> out_valid exactly 25 cycles
//   after accept; digest equals golden model of round/final equations.
// - Two-block message (first, then last) -> digest equals model of chained H^m; second block
//   accepted only in WAIT, in_ready=0 throughout both ROUND phases.
// - Back-pressure: out_ready=0 for 10 cycles -> out_valid and digest stable, in_ready=0; out_ready=1
//   -> out_valid low next cycle, in_ready=1.
// - Restart: in_first block in WAIT -> old chain discarded; digest equals single-block result.
// - Non-first block in IDLE and iv toggled during ROUND -> ignored; digest unchanged vs clean run.

Source files
------------

// File: rtl/hash_light_pkg.sv
// ----------------------------------------------------------------------------
// hash_light_pkg : shared types and helpers for the lightweight hash (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package hash_light_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROUND = 3'd1,
    WAIT  = 3'd2,
    FINAL = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam int ROT_AMT = 3;

  function automatic logic [7:0] rotl8(input logic [7:0] x);
    return {x[7-ROT_AMT:0], x[7:8-ROT_AMT]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/hash_light_round.sv
// ----------------------------------------------------------------------------
// hash_light_round : one combinational mixing round over the chaining state (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module hash_light_round
  import hash_light_pkg::*;
#(
  parameter int N_BYTES = 4
) (
  input  logic [8*N_BYTES-1:0] h,
  input  logic [8*N_BYTES-1:0] iv_q,
  input  logic [7:0]           r,
  output logic [8*N_BYTES-1:0] h_next
);

  genvar i;
  generate
    for (i = 0; i < N_BYTES; i++) begin : g_byte
      logic [7:0] w_x;
      logic [7:0] w_sum;
      // every byte reads the old state, so all bytes update in parallel
      assign w_x   = h[8*((i+1)%N_BYTES) +: 8] ^ iv_q[8*i +: 8] ^ r;
      assign w_sum = h[8*i +: 8] + w_x;
      assign h_next[8*i +: 8] = rotl8(w_sum);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/hash_light_stream.sv
// ----------------------------------------------------------------------------
// hash_light_stream : iterative multi-block hash engine with held digest output (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module hash_light_stream
  import hash_light_pkg::*;
#(
  parameter int N_BYTES  = 4,
  parameter int N_ROUNDS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [8*N_BYTES-1:0] in_block,
  input  logic [8*N_BYTES-1:0] iv,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*N_BYTES-1:0] digest,
  output logic                 busy
);

  localparam int RC_W = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(N_ROUNDS - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [8*N_BYTES-1:0] r_h;
  logic [8*N_BYTES-1:0] r_iv;
  logic [8*N_BYTES-1:0] r_digest;
  logic [RC_W-1:0]      r_rc;
  logic                 r_last;
  logic [8*N_BYTES-1:0] w_h_next;
  logic [8*N_BYTES-1:0] w_fin;
  logic                 w_accept;

  assign w_accept = in_valid & in_ready;
  assign digest   = r_digest;

  hash_light_round #(
    .N_BYTES (N_BYTES)
  ) u_round (
    .h      (r_h),
    .iv_q   (r_iv),
    .r      (8'(r_rc)),
    .h_next (w_h_next)
  );

  // digest byte i mixes with the mirrored IV byte
  genvar i;
  generate
    for (i = 0; i < N_BYTES; i++) begin : g_fin
      assign w_fin[8*i +: 8] = r_h[8*i +: 8] ^ r_iv[8*(N_BYTES-1-i) +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && in_first) w_state_next = ROUND;
      end
      WAIT: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (r_rc == RC_LAST) w_state_next = r_last ? FINAL : WAIT;
      end
      FINAL: begin
        busy         = 1'b1;
        w_state_next = OUT;
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h      <= '0;
      r_iv     <= '0;
      r_digest <= '0;
      r_rc     <= '0;
      r_last   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, WAIT: begin
          // a first block always restarts the chain, even mid-message
          if (w_accept && in_first) begin
            r_iv   <= iv;
            r_h    <= in_block;
            r_rc   <= '0;
            r_last <= in_last;
          end else if (w_accept && (r_state == WAIT)) begin
            r_h    <= r_h ^ in_block;
            r_rc   <= '0;
            r_last <= in_last;
          end
        end
        ROUND: begin
          r_h  <= w_h_next;
          r_rc <= (r_rc == RC_LAST) ? '0 : r_rc + RC_W'(1);
        end
        FINAL: r_digest <= w_fin;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hash_light_stream.sv
// ----------------------------------------------------------------------------
// tb_hash_light_stream : directed vector bench for the lightweight hash engine (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hash_light_stream;

  localparam int NB = 4;
  localparam int NR = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_block = '0;
  logic [31:0] iv = '0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [31:0] digest;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        two;
    logic [31:0] m0;
    logic [31:0] m1;
    logic [31:0] v;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[4];

  hash_light_stream #(
    .N_BYTES  (NB),
    .N_ROUNDS (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_block  (in_block),
    .iv        (iv),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digest    (digest),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_round(input logic [31:0] h, input logic [31:0] v, input int r);
    logic [7:0]  x;
    logic [7:0]  s;
    logic [7:0]  rb;
    logic [31:0] o;
    rb = 8'(r);
    o  = '0;
    for (int b = 0; b < NB; b++) begin
      x = h[8*((b+1)%NB) +: 8] ^ v[8*b +: 8] ^ rb;
      s = h[8*b +: 8] + x;
      o[8*b +: 8] = {s[4:0], s[7:5]};
    end
    return o;
  endfunction

  function automatic logic [31:0] m_rounds(input logic [31:0] h, input logic [31:0] v);
    logic [31:0] t;
    t = h;
    for (int r = 0; r < NR; r++) t = m_round(t, v, r);
    return t;
  endfunction

  function automatic logic [31:0] model(input logic [31:0] m0, input logic [31:0] m1,
                                        input logic [31:0] v, input logic two);
    logic [31:0] h;
    logic [31:0] d;
    h = m_rounds(m0, v);
    if (two) h = m_rounds(h ^ m1, v);
    for (int b = 0; b < NB; b++) d[8*b +: 8] = h[8*b +: 8] ^ v[8*(NB-1-b) +: 8];
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic send(input logic f, input logic l, input logic [31:0] b, input logic [31:0] v);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
    in_block = b;
    iv       = v;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("send_ready_timeout", 32'(guard < 200), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int lat, output int rdy_hi);
    lat    = 0;
    rdy_hi = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_hi++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume(input string name, input logic [31:0] exp, input int exp_lat);
    int lat;
    int rdy_hi;
    wait_out(lat, rdy_hi);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_ready_low"}, 32'(rdy_hi), 32'd0);
    check({name, "_digest"}, digest, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int bad;
    int lat;
    int rdy_hi;
    logic [31:0] d0;

    vecs[0] = '{1'b0, 32'h0403_0201, 32'h0, 32'h0000_0000, 32'h0};
    vecs[1] = '{1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0123_4567, 32'h0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0};
    vecs[3] = '{1'b1, 32'h0403_0201, 32'hA5A5_5A5A, 32'h1111_2222, 32'h0};
    for (int k = 0; k < 4; k++)
      vecs[k].exp = model(vecs[k].m0, vecs[k].m1, vecs[k].v, vecs[k].two);

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_digest", digest, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) begin
      send(1'b1, !vecs[k].two, vecs[k].m0, vecs[k].v);
      if (vecs[k].two) begin
        bad = 0;
        for (int c = 1; c <= NR; c++) begin
          @(posedge clk); #1;
          if (c < NR && in_ready) bad++;
        end
        check("chain_ready_low_r1", 32'(bad), 32'd0);
        check("chain_wait_ready", 32'(in_ready), 32'd1);
        send(1'b0, 1'b1, vecs[k].m1, vecs[k].v);
      end
      consume($sformatf("vec%0d", k), vecs[k].exp, NR + 1);
    end

    // back-pressure: digest must hold while the consumer stalls
    send(1'b1, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_out(lat, rdy_hi);
    check("bp_latency", 32'(lat), 32'(NR + 1));
    d0  = digest;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!out_valid || digest !== d0 || in_ready) bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    check("bp_digest", digest, model(32'h1234_5678, 32'h0, 32'h9ABC_DEF0, 1'b0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_in_ready", 32'(in_ready), 32'd1);

    // restart: a first block arriving in WAIT discards the old chain
    send(1'b1, 1'b0, 32'h1122_3344, 32'h5566_7788);
    repeat (NR) begin
      @(posedge clk); #1;
    end
    check("restart_wait_ready", 32'(in_ready), 32'd1);
    send(1'b1, 1'b1, 32'hCAFE_F00D, 32'h0BAD_C0DE);
    consume("restart", model(32'hCAFE_F00D, 32'h0, 32'h0BAD_C0DE, 1'b0), NR + 1);

    // non-first block in IDLE is dropped; iv wiggles during rounds are ignored
    in_valid = 1'b1;
    in_first = 1'b0;
    in_last  = 1'b1;
    in_block = 32'hFFFF_0000;
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy || !in_ready) bad++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("idle_drop", 32'(bad), 32'd0);
    send(1'b1, 1'b1, 32'h0403_0201, 32'h0000_0000);
    repeat (10) begin
      @(posedge clk); #1;
      iv = $urandom;
    end
    consume("iv_toggle", vecs[0].exp, NR + 1 - 10);

    // asynchronous reset in the middle of the rounds
    send(1'b1, 1'b1, 32'h5555_AAAA, 32'h3333_CCCC);
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_digest", digest, 32'h0);
    rst = 1'b0;
    bad = 0;
    repeat (NR + 10) begin
      @(posedge clk); #1;
      if (out_valid || busy) bad++;
    end
    check("mid_rst_no_digest", 32'(bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
